// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the iterative RV32M multiply/divide unit and the
//   decode stage that drives it.
//   - DATA_WIDTH : datapath width (only 32 is supported)
//   - op_e       : RV32M funct3 encodings MUL..REMU
//   - state_e    : sequencer states IDLE / CALC / DONE
package muldiv_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit. Multiplies with a radix-2 shift-add
//   and divides with restoring division, both on operand magnitudes, with the
//   sign applied when the result is written.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, op, a, b: request strobe (taken when ready), funct3, rs1, rs2
//   flush          : abort whatever is in flight, back to IDLE
//   ready, busy    : ready in IDLE/DONE, busy in CALC
//   done, result   : one-cycle pulse with the selected result, held afterwards
//   zero           : result equals zero
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int ITER  = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state, next_state;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] mag;
  op_e              op_r;
  logic             neg_q, neg_r;

  logic             accept, a_signed, b_signed, a_neg, b_neg;
  logic             div_zero, div_ovf, fast_path;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, final_res;

  assign accept = start && ready && !flush;

  // Operand decode for the request on the inputs: signedness per op,
  // magnitudes, and the two division cases that bypass the iteration.
  always_comb begin
    a_signed  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                (op == OP_DIV) || (op == OP_REM);
    b_signed  = (op == OP_MUL) || (op == OP_MULH) ||
                (op == OP_DIV) || (op == OP_REM);
    a_neg     = a_signed && a[WIDTH-1];
    b_neg     = b_signed && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    div_zero  = op[2] && (b == '0);
    div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    fast_path = div_zero || div_ovf;
  end

  // One iteration step. Multiply adds the multiplicand when the multiplier
  // LSB is set and shifts {acc, sh} right; divide shifts the next dividend
  // bit into the partial remainder and subtracts when it fits. The remainder
  // stays below the divisor, so a WIDTH-bit difference is exact.
  always_comb begin
    mul_sum   = {1'b0, acc} + (sh[0] ? {1'b0, mag} : '0);
    div_trial = {acc, sh[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, mag};
    div_diff  = div_trial[WIDTH-1:0] - mag;
  end

  // Sign correction and op selection applied on the way out of DONE.
  always_comb begin
    prod   = {acc, sh};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -sh : sh;
    rem_s  = neg_r ? -acc : acc;
    case (op_r)
      OP_MUL:                       final_res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              final_res = quo_s;
      default:                      final_res = rem_s;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; flush wins over everything, including a start.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = fast_path ? DONE : CALC;
      CALC: if (cnt == CNT_W'(ITER-1)) next_state = DONE;
      DONE: if (start) next_state = fast_path ? DONE : CALC;
            else       next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  // Status outputs.
  always_comb begin
    ready = (state != CALC);
    busy  = (state == CALC);
  end

  // Datapath. The DONE cycle writes the result and raises done at its exit
  // edge; a start taken in that same cycle loads the next operation from
  // the live inputs while the finished one is still being written out.
  // Fast-path requests preload sh/acc with the architected answer so the
  // shared output logic produces it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      sh     <= '0;
      mag    <= '0;
      op_r   <= OP_MUL;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == DONE && !flush) begin
        result <= final_res;
        done   <= 1'b1;
      end
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        op_r <= op_e'(op);
        cnt  <= '0;
        acc  <= '0;
        if (fast_path) begin
          sh    <= div_zero ? '1 : MIN_NEG;
          acc   <= div_zero ? a : '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (op[2]) begin
          sh    <= a_mag;
          mag   <= b_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end else begin
          sh    <= b_mag;
          mag   <= a_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= 1'b0;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (op_r[2]) begin
          acc <= div_ge ? div_diff : div_trial[WIDTH-1:0];
          sh  <= {sh[WIDTH-2:0], div_ge};
        end else begin
          acc <= mul_sum[WIDTH:1];
          sh  <= {mul_sum[0], sh[WIDTH-1:1]};
        end
      end
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed self-checking bench for muldiv_unit. Latency is counted in
//   rising edges starting with the edge that accepts the request.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        ready, busy, done, zero;
  logic [31:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .ready(ready), .busy(busy), .done(done),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for done. lat = -1 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int lat,
                        output logic [31:0] res, output logic z);
    int edges;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); edges = 1; #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    while (!done && edges < 100) begin
      @(posedge clk); edges++; #1;
    end
    lat = done ? edges : -1;
    res = result;
    z   = zero;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests_run++;
    if ({ready, busy, done, zero} !== 4'b1001) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 1001", {ready, busy, done, zero});
    end
    tests_run++;
    if (result !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result: got %h expected 00000000", result);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul;
    int lat; logic [31:0] r; logic z;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, lat, r, z);
    tests_run++;
    if (lat !== 34) begin tests_failed++; $display("[TB] FAIL mul_latency: got %0d expected 34", lat); end
    tests_run++;
    if (r !== 32'hFFFF_FFEB) begin tests_failed++; $display("[TB] FAIL mul_result: got %h expected ffffffeb", r); end
    tests_run++;
    if (z !== 1'b0) begin tests_failed++; $display("[TB] FAIL mul_zero: got %b expected 0", z); end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || result !== 32'hFFFF_FFEB) begin
      tests_failed++;
      $display("[TB] FAIL mul_done_pulse: got done=%b result=%h expected done=0 result=ffffffeb", done, result);
    end
  endtask

  task automatic test_mulh;
    int lat; logic [31:0] r; logic z;
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, r, z);
    tests_run++;
    if (r !== 32'hFFFF_FFFE) begin tests_failed++; $display("[TB] FAIL mulhu_result: got %h expected fffffffe", r); end
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, r, z);
    tests_run++;
    if (r !== 32'h0 || z !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mulh_result: got %h zero=%b expected 00000000 zero=1", r, z);
    end
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, r, z);
    tests_run++;
    if (r !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL mulhsu_result: got %h expected ffffffff", r); end
  endtask

  task automatic test_div;
    int lat; logic [31:0] r; logic z;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, lat, r, z);
    tests_run++;
    if (r !== 32'hFFFF_FFFD) begin tests_failed++; $display("[TB] FAIL div_result: got %h expected fffffffd", r); end
    tests_run++;
    if (lat !== 34) begin tests_failed++; $display("[TB] FAIL div_latency: got %0d expected 34", lat); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, lat, r, z);
    tests_run++;
    if (r !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL rem_result: got %h expected ffffffff", r); end
    run_op(3'b111, 32'd100, 32'd7, lat, r, z);
    tests_run++;
    if (r !== 32'd2) begin tests_failed++; $display("[TB] FAIL remu_result: got %h expected 00000002", r); end
  endtask

  task automatic test_fast_path;
    int lat; logic [31:0] r; logic z;
    run_op(3'b101, 32'd5, 32'd0, lat, r, z);
    tests_run++;
    if (lat !== 2 || r !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL divu_by_zero: got lat=%0d result=%h expected lat=2 result=ffffffff", lat, r);
    end
    run_op(3'b111, 32'd5, 32'd0, lat, r, z);
    tests_run++;
    if (lat !== 2 || r !== 32'd5) begin
      tests_failed++;
      $display("[TB] FAIL remu_by_zero: got lat=%0d result=%h expected lat=2 result=00000005", lat, r);
    end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, z);
    tests_run++;
    if (lat !== 2 || r !== 32'h0 || z !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rem_overflow: got lat=%0d result=%h zero=%b expected lat=2 result=00000000 zero=1", lat, r, z);
    end
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, z);
    tests_run++;
    if (lat !== 2 || r !== 32'h8000_0000) begin
      tests_failed++;
      $display("[TB] FAIL div_overflow: got lat=%0d result=%h expected lat=2 result=80000000", lat, r);
    end
  endtask

  task automatic test_ignore_start;
    int edges;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd7;
    @(posedge clk); edges = 1; #1;
    start = 1'b0;
    while (!done && edges < 100) begin
      if (edges == 5) begin start = 1'b1; op = 3'b101; a = 32'd9; b = 32'd3; end
      if (edges == 6) start = 1'b0;
      @(posedge clk); edges++; #1;
    end
    tests_run++;
    if (edges !== 34 || result !== 32'd42) begin
      tests_failed++;
      $display("[TB] FAIL ignore_start: got edges=%0d result=%h expected edges=34 result=0000002a", edges, result);
    end
  endtask

  task automatic test_flush;
    int lat; int edges; int seen; logic [31:0] r; logic z;
    run_op(3'b000, 32'd3, 32'd5, lat, r, z);
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd1000; b = 32'd10;
    @(posedge clk); edges = 1; #1;
    start = 1'b0;
    while (edges < 10) begin @(posedge clk); edges++; #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_ready: got ready=%b busy=%b expected ready=1 busy=0", ready, busy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (seen !== 0 || result !== 32'd15) begin
      tests_failed++;
      $display("[TB] FAIL flush_no_done: got dones=%0d result=%h expected dones=0 result=0000000f", seen, result);
    end
    // Flush together with a start: the start is dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_over_start: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_calc;
    int lat; int edges; int seen; logic [31:0] r; logic z;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd11; b = 32'd13;
    @(posedge clk); edges = 1; #1;
    start = 1'b0;
    while (edges < 20) begin @(posedge clk); edges++; #1; end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ready, busy, done, zero} !== 4'b1001 || result !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_calc: got flags=%b result=%h expected flags=1001 result=00000000",
               {ready, busy, done, zero}, result);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("[TB] FAIL reset_no_done: got dones=%0d expected 0", seen); end
    run_op(3'b101, 32'd100, 32'd7, lat, r, z);
    tests_run++;
    if (r !== 32'd14 || lat !== 34) begin
      tests_failed++;
      $display("[TB] FAIL divu_after_reset: got lat=%0d result=%h expected lat=34 result=0000000e", lat, r);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_ignore_start();
    test_flush();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter ITER, default 32, number of iteration cycles; equals WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request strobe; accepted only when ready=1.
REQ-006 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port a  input  WIDTH  operand rs1 (dividend / multiplicand).
REQ-008 SHALL have port b  input  WIDTH  operand rs2 (divisor / multiplier).
REQ-009 SHALL have port flush  input  1  abort the in-flight operation.
REQ-010 SHALL have port ready  output  1  high in IDLE and DONE; a start is accepted.
REQ-011 SHALL have port busy  output  1  high in CALC.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-013 SHALL have port result  output  WIDTH  product/quotient/remainder selected by op.
REQ-014 SHALL have port zero  output  1  high when result equals 0, matching ALU zero semantics.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on an accepted start; CALC->DONE when the iteration counter reaches ITER-1; DONE->IDLE after one cycle, or DONE->CALC on a start in DONE.
REQ-016 SHALL register a, b and op on the accepting edge; later operand changes SHALL NOT affect the operation.
REQ-017 SHALL take, for a normal operation accepted at edge T, exactly ITER edges in CALC and assert done during the cycle after edge T+ITER+1 (latency ITER+2 edges, 34 at default).
REQ-018 SHALL hold result stable from done until the next accepted start completes; done SHALL be high for exactly one cycle.
REQ-019 SHALL compute multiply as a radix-2 shift-add over a 2*WIDTH product on sign-adjusted magnitudes: MUL returns the low WIDTH bits; MULH treats a and b as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned; MULH/MULHSU/MULHU return the high WIDTH bits.
REQ-020 SHALL compute divide by restoring division on magnitudes: quotient sign = sign(a) XOR sign(b) for DIV; remainder sign = sign(a) for REM.
REQ-021 SHALL, for divide by zero (b=0), skip CALC and go IDLE->DONE in one edge: DIV/DIVU result all-ones; REM/REMU result = a.
REQ-022 SHALL, for signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF), take the same one-edge fast path: DIV result 0x80000000; REM result 0.
REQ-023 SHALL ignore start while busy=1; no queueing.
REQ-024 SHALL return to IDLE on a flush in any state on the next edge, with no done pulse and result unchanged; flush SHALL override a simultaneous start.
REQ-025 SHALL derive zero combinationally from the registered result.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force state=IDLE, counter=0, result=0, done=0, busy=0 and ready=1; zero is then 1.
REQ-027 SHALL abandon any operation in progress on reset assertion mid-CALC, with no done pulse after release.
REQ-028 SHALL accept a start on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the op encodings (MUL..REMU), the state enum and the WIDTH constant in shared package muldiv_pkg, which the decode stage also imports.
REQ-030 SHALL be a single module with no sub-module; the negate/magnitude logic and the iterative datapath are inline.
REQ-031 SHALL size the iteration counter at $clog2(ITER) bits and let it wrap to 0 on CALC exit.

Verification
REQ-032 SHALL cover: MUL a=7, b=-3 (0xFFFFFFFD) -> done at edge 34, result 0xFFFFFFEB, zero=0.
REQ-033 SHALL cover: MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; with the same operands MULH -> result 0x00000000, zero=1.
REQ-034 SHALL cover: DIV a=-7, b=2 -> result 0xFFFFFFFD (-3); REM with the same operands -> result 0xFFFFFFFF (-1).
REQ-035 SHALL cover: DIVU a=5, b=0 -> done after 2 edges, result 0xFFFFFFFF; REM a=0x80000000, b=-1 -> done after 2 edges, result 0.
REQ-036 SHALL cover: start re-pulsed with new operands mid-CALC -> ignored and original result returned; flush at iteration 10 -> ready next cycle and no done.
REQ-037 SHALL cover: rst_n pulsed low at iteration 20 -> outputs at reset values immediately; a new DIVU 100/7 started after release -> result 14.
